// File: rtl/sap_sequencer.sv
// SAP-class control sequencer: one-hot T-state ring plus opcode decode into the control word.
// Optional early end of each instruction is enabled by defining SAP_SEQ_EARLY_END_EN.
module sap_sequencer #(
   parameter int OPCODE_W = 4,
   parameter int T_STATES = 6
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                run,
   input  logic [OPCODE_W-1:0] opcode,
   output logic                Cp,
   output logic                Ep,
   output logic                Lm,
   output logic                Ce,
   output logic                Li,
   output logic                Ei,
   output logic                La,
   output logic                Ea,
   output logic                Su,
   output logic                Eu,
   output logic                Lb,
   output logic                Lo,
   output logic                Lp,
   output logic [T_STATES-1:0] t_state,
   output logic                halted
);

   typedef enum logic [2:0] {
      INSTR_LDA,
      INSTR_ADD,
      INSTR_SUB,
      INSTR_JMP,
      INSTR_OUT,
      INSTR_HLT,
      INSTR_NOP
   } instr_t;

   logic [T_STATES-1:0] r_tState;
   logic                r_halted;
   logic                w_upperClear;
   logic                w_enable;
   logic                w_wrap;
   instr_t              w_instr;

   // Any set bit above the low nibble turns the opcode into a NOP.
   generate
      if (OPCODE_W > 4) begin : g_upper
         assign w_upperClear = (opcode[OPCODE_W-1:4] == '0);
      end else begin : g_noUpper
         assign w_upperClear = 1'b1;
      end
   endgenerate

   always_comb begin
      w_instr = INSTR_NOP;
      if (w_upperClear) begin
         case (opcode[3:0])
            4'h0:    w_instr = INSTR_LDA;
            4'h1:    w_instr = INSTR_ADD;
            4'h2:    w_instr = INSTR_SUB;
            4'h3:    w_instr = INSTR_JMP;
            4'hE:    w_instr = INSTR_OUT;
            4'hF:    w_instr = INSTR_HLT;
            default: w_instr = INSTR_NOP;
         endcase
      end
   end

`ifdef SAP_SEQ_EARLY_END_EN
   logic w_lastStep;

   // Marks the final microstep that does real work for the current instruction.
   always_comb begin
      case (w_instr)
         INSTR_LDA:                       w_lastStep = r_tState[4];
         INSTR_ADD, INSTR_SUB:            w_lastStep = r_tState[5];
         INSTR_JMP, INSTR_OUT, INSTR_HLT: w_lastStep = r_tState[3];
         default:                         w_lastStep = r_tState[2];
      endcase
   end

   assign w_wrap = r_tState[T_STATES-1] | w_lastStep;
`else
   assign w_wrap = r_tState[T_STATES-1];
`endif

   assign w_enable = reset & run & ~r_halted;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_tState <= T_STATES'(1);
         r_halted <= 1'b0;
      end else if (run && !r_halted) begin
         if (r_tState[3] && (w_instr == INSTR_HLT)) begin
            r_halted <= 1'b1;
         end else if (w_wrap) begin
            r_tState <= T_STATES'(1);
         end else begin
            r_tState <= {r_tState[T_STATES-2:0], 1'b0};
         end
      end
   end

   // Microcode table; states past T6 are padding and stay silent.
   always_comb begin
      Cp = 1'b0; Ep = 1'b0; Lm = 1'b0; Ce = 1'b0; Li = 1'b0; Ei = 1'b0; La = 1'b0;
      Ea = 1'b0; Su = 1'b0; Eu = 1'b0; Lb = 1'b0; Lo = 1'b0; Lp = 1'b0;
      if (w_enable) begin
         if (r_tState[0]) begin
            Ep = 1'b1;
            Lm = 1'b1;
         end
         if (r_tState[1]) begin
            Cp = 1'b1;
         end
         if (r_tState[2]) begin
            Ce = 1'b1;
            Li = 1'b1;
         end
         if (r_tState[3]) begin
            case (w_instr)
               INSTR_LDA, INSTR_ADD, INSTR_SUB: begin Ei = 1'b1; Lm = 1'b1; end
               INSTR_JMP:                       begin Ei = 1'b1; Lp = 1'b1; end
               INSTR_OUT:                       begin Ea = 1'b1; Lo = 1'b1; end
               default: ;
            endcase
         end
         if (r_tState[4]) begin
            case (w_instr)
               INSTR_LDA:            begin Ce = 1'b1; La = 1'b1; end
               INSTR_ADD, INSTR_SUB: begin Ce = 1'b1; Lb = 1'b1; end
               default: ;
            endcase
         end
         if (r_tState[5]) begin
            case (w_instr)
               INSTR_ADD: begin Eu = 1'b1; La = 1'b1; end
               INSTR_SUB: begin Su = 1'b1; Eu = 1'b1; La = 1'b1; end
               default: ;
            endcase
         end
      end
   end

   assign t_state = r_tState;
   assign halted  = r_halted;

endmodule

// File: doc/sap_sequencer.md
# sap_sequencer

Parametrised control sequencer for the SAP-class computer. It replaces the fixed six-state control unit.
- Steps a one-hot T-state ring counter and decodes the current opcode from the instruction register into the control word that drives the program counter, MAR, RAM, IR, accumulator, ALU, B and output registers.
- Adds a jump instruction, a sticky halt, a run/pause input and a configurable number of T-states.
- Optionally ends each instruction early, after its last active microstep.

## Interface
- `OPCODE_W`, default 4: opcode width. Only the low 4 bits select an instruction. Any nonzero upper bit decodes as NOP.
- `T_STATES`, default 6: ring-counter length, legal range 6..8. States T7..T8 are idle padding for slow memory.
- `clk` in 1: system clock. All state changes on its rising edge.
- `reset` in 1: synchronous, active-low reset.
- `run` in 1: step enable. When 0, the T-state holds and all control outputs are forced to 0.
- `opcode` in `OPCODE_W`: instruction-register output. Valid from T4.
- `Cp`, `Ep`, `Lm`, `Ce`, `Li`, `Ei`, `La`, `Ea`, `Su`, `Eu`, `Lb`, `Lo` out 1 each: control word, active-high.
- `Lp` out 1: program-counter load for jumps (new).
- `t_state` out `T_STATES`: one-hot current state; bit 0 is T1.
- `halted` out 1: sticky halt flag.

## Operation
- **Fetch**, common to all instructions:
  - T1: `Ep`, `Lm`.
  - T2: `Cp`.
  - T3: `Ce`, `Li`.
- **Execute**, low 4 opcode bits:
  - LDA 0000: T4 `Ei`, `Lm`; T5 `Ce`, `La`.
  - ADD 0001: T4 `Ei`, `Lm`; T5 `Ce`, `Lb`; T6 `Eu`, `La`.
  - SUB 0010: T4 `Ei`, `Lm`; T5 `Ce`, `Lb`; T6 `Su`, `Eu`, `La`.
  - JMP 0011: T4 `Ei`, `Lp`.
  - OUT 1110: T4 `Ea`, `Lo`.
  - HLT 1111: T4 sets `halted` and asserts no control bits.
  - All other codes are NOP: no execute steps.
- Control outputs are combinational from `t_state` and `opcode`. They are forced to 0 when `reset` is 0, `run` is 0 or `halted` is 1.
- **Ring advance:** with `run` = 1 and not halted, the counter advances one state per clock. It returns to T1 after state T`T_STATES`, or earlier when the early-end option is active.
- **Halt:** the rising edge that ends T4 of HLT sets `halted`. `t_state` freezes at T4. Only `reset` clears the halt; `run` has no effect while halted.
- **Reset values:** `t_state` = one-hot T1, `halted` = 0, all control outputs 0.

## Timing
- One T-state per `clk` while `run` = 1.
- `opcode` is sampled combinationally in T4..T6. The IR loads on the edge ending T3.
- Instruction length with early end, in cycles: NOP 3, JMP 4, OUT 4, LDA 5, ADD 6, SUB 6. Without early end, every instruction takes `T_STATES` cycles.
- HLT: `halted` is 1 from the cycle after T4.
- `run` falling mid-instruction:
  - The state held is the one current at the edge where `run` is first sampled 0.
  - Outputs are 0 in the same cycle.
  - On resume, the held step's control word is reasserted once; it is not skipped or repeated.
- Reset mid-instruction: the next edge forces T1 and clears `halted`, whatever `run` is.
- Reset has priority over `run` and halt.

## Configuration
- `SAP_SEQ_EARLY_END_EN` defined: after the last active microstep of the current opcode, the next state is T1. This covers NOP after T3 and HLT freezing at T4.
- Undefined: the counter walks all `T_STATES` states. States past the last active step assert no control bits.

## Test plan
- **Reset and fetch:** hold `reset` = 0 for 2 clocks, then release with `run` = 1. Expect `t_state` = 000001, then control words `Ep`/`Lm` → `Cp` → `Ce`/`Li` on three consecutive cycles, `halted` = 0.
- **SUB, early end:** opcode 0010 with early end defined. T6 asserts `Su`, `Eu`, `La` only, and the next cycle is T1, so the instruction takes 6 cycles.
- **LDA length:** opcode 0000, `T_STATES` = 8.
  - With the macro: back to T1 after 5 cycles.
  - Without: 8 cycles, with T6..T8 outputs all 0.
- **JMP then HLT:** opcode 0011 gives `Ei`/`Lp` in T4 and the next state is T1. Then opcode 1111: `halted` = 1 after T4, `t_state` stays at T4 for 10 further clocks, and the control word stays 0.
- **Pause:** drop `run` during T2 for 3 clocks. `Cp` is 0 and `t_state` holds at T2 throughout. After `run` returns, `Cp` is asserted exactly one cycle.
- **Illegal opcode:** `OPCODE_W` = 6, opcode 010001. Decodes as NOP: 3-cycle instruction with early end, no execute-phase control bits.
